delay_var_ring: RTL and testbench

- Programmable-latency 32-bit delay line with a valid tag, for the datapath stages that need the delay set at run time rather than fixed at build time.
- Built as a circular buffer (write pointer plus derived read tap) instead of a chain of registers.
- Lets one instance balance branches whose latency differs by mode; out carries in delayed by a selected 1..DEPTH cycles.
- Sits between datapath stages, same clk/GlobalReset domain as the fixed delay stages.

---
 rtl/delay_var_ring.sv | 136 +++++++++++++
 tb/tb_delay_var_ring.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_var_ring.sv
// delay_var_ring: run-time programmable delay line (1..DEPTH advance cycles)
// built on a circular buffer. A write pointer walks the storage ring. The read
// tap sits D_act slots behind it, so the sample read out is the one written
// D_act advances earlier. A fill counter gates the output while the ring still
// holds fewer than D_act samples since the last restart.
module delay_var_ring #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int SELW  = 6
) (
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   input  logic [SELW-1:0]  delay_sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             filling,
   output logic             cfg_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SELW-1:0] DEPTH_SEL = SELW'(DEPTH);

   // Data ring: plain array so it can map onto block RAM. The valid tags live
   // in flops because a delay change has to clear all of them at once.
   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [DEPTH-1:0] valid_reg;

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    wr_ptr_next;
   logic [PW-1:0]    rd_tap;
   logic [SELW-1:0]  d_act_reg;
   logic [SELW-1:0]  d_act_next;
   logic [SELW-1:0]  fill_cnt_reg;
   logic [SELW-1:0]  fill_cnt_next;
   logic [WIDTH-1:0] out_reg;
   logic             out_valid_reg;
   logic             filling_reg;
   logic             cfg_err_reg;

   logic             sel_legal;
   logic             sel_change;
   logic             sel_bad;
   logic             line_full;

   // Decode the requested delay and work out next pointer, delay and fill count.
   always_comb begin
      sel_legal  = (delay_sel != '0) && (delay_sel <= DEPTH_SEL);
      sel_change = en && sel_legal && (delay_sel != d_act_reg);
      sel_bad    = en && !sel_legal;
      d_act_next = sel_change ? delay_sel : d_act_reg;

      // On a restart, the sample arriving in the same cycle is the first one
      // counted at the new delay. Otherwise the count saturates at D_act.
      if (sel_change) begin
         fill_cnt_next = SELW'(1);
      end else if (fill_cnt_reg < d_act_reg) begin
         fill_cnt_next = fill_cnt_reg + SELW'(1);
      end else begin
         fill_cnt_next = fill_cnt_reg;
      end

      // DEPTH is a power of two, so the low PW bits give the modulo. When
      // D_act equals DEPTH, the tap equals the write pointer. The data is then
      // read before that slot is overwritten in the same edge.
      rd_tap      = wr_ptr_reg - d_act_reg[PW-1:0];
      wr_ptr_next = wr_ptr_reg + PW'(1);

      // The output is only meaningful once D_act samples are stored. A restart
      // drops everything that is in flight.
      line_full = !sel_change && (fill_cnt_reg >= d_act_reg);
   end

   // Control state: pointer, active delay, fill progress and status flags.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         wr_ptr_reg    <= '0;
         fill_cnt_reg  <= '0;
         d_act_reg     <= SELW'(1);
         out_valid_reg <= 1'b0;
         filling_reg   <= 1'b1;
         cfg_err_reg   <= 1'b0;
      end else if (en) begin
         wr_ptr_reg    <= wr_ptr_next;
         fill_cnt_reg  <= fill_cnt_next;
         d_act_reg     <= d_act_next;
         out_valid_reg <= line_full && valid_reg[rd_tap];
         filling_reg   <= (fill_cnt_next < d_act_next);
         if (sel_bad) begin
            cfg_err_reg <= 1'b1;
         end
      end
   end

   // Ring write: storage is not cleared. Stale data is masked by the fill gate.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[wr_ptr_reg] <= in;
      end
   end

   // Registered read of the tap, forced to zero while the line is filling.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         out_reg <= '0;
      end else if (en) begin
         out_reg <= line_full ? mem[rd_tap] : '0;
      end
   end

   // One flop per slot for the valid tag. The slot being written takes the new
   // tag. On a restart, every other slot is cleared.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (GlobalReset) begin
               valid_reg[gi] <= 1'b0;
            end else if (en) begin
               if (wr_ptr_reg == PW'(gi)) begin
                  valid_reg[gi] <= in_valid;
               end else if (sel_change) begin
                  valid_reg[gi] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign filling   = filling_reg;
   assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_delay_var_ring.sv
// Testbench for delay_var_ring. A queue-based reference model keeps the
// samples accepted since the last restart. On each advance cycle, out is the
// sample D positions back in that history, or zero if too few are held.
module tb_delay_var_ring;
   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int SELW  = 6;

   logic             clk = 1'b0;
   logic             GlobalReset;
   logic             en;
   logic [WIDTH-1:0] in_d;
   logic             in_valid;
   logic [SELW-1:0]  delay_sel;
   logic [WIDTH-1:0] out_d;
   logic             out_valid;
   logic             filling;
   logic             cfg_err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [WIDTH:0]   hist[$];
   int               d_mod;
   logic             cfg_mod;
   logic [WIDTH-1:0] exp_out;
   logic             exp_ov;
   logic             exp_fill;

   delay_var_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW)) dut (
      .clk(clk), .GlobalReset(GlobalReset), .en(en), .in(in_d),
      .in_valid(in_valid), .delay_sel(delay_sel), .out(out_d),
      .out_valid(out_valid), .filling(filling), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      hist.delete();
      d_mod    = 1;
      cfg_mod  = 1'b0;
      exp_out  = '0;
      exp_ov   = 1'b0;
      exp_fill = 1'b1;
   endfunction

   function automatic void model_advance(input logic [WIDTH-1:0] d, input logic v, input int s);
      logic [WIDTH:0] e;
      if (s < 1 || s > DEPTH) begin
         cfg_mod = 1'b1;
      end else if (s != d_mod) begin
         d_mod = s;
         hist.delete();
      end
      if (hist.size() >= d_mod) begin
         e = hist[hist.size() - d_mod];
         exp_ov  = e[WIDTH];
         exp_out = e[WIDTH-1:0];
      end else begin
         exp_ov  = 1'b0;
         exp_out = '0;
      end
      hist.push_back({v, d});
      if (hist.size() > DEPTH + 2) void'(hist.pop_front());
      exp_fill = (hist.size() < d_mod);
   endfunction

   // Drives one clock cycle, advances the model, and prints the transaction.
   task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d,
                       input logic v, input logic [SELW-1:0] s);
      GlobalReset = r; en = e; in_d = d; in_valid = v; delay_sel = s;
      @(posedge clk);
      #1;
      if (r) model_reset();
      else if (e) model_advance(d, v, int'(s));
      $display("[TB] rst=%b en=%b sel=%0d in=%h/%b -> out=%h/%b fill=%b err=%b",
               r, e, s, d, v, out_d, out_valid, filling, cfg_err);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'b1, 6'd4);
      step(1'b1, 1'b1, $urandom, 1'b1, 6'd7);
      n_tests++;
      if ({out_d, out_valid, filling, cfg_err} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: out=%h v=%b fill=%b err=%b, expected 0/0/1/0",
                  out_d, out_valid, filling, cfg_err);
      end
   endtask

   task automatic test_fill_d5();
      for (int k = 1; k <= 14; k++) begin
         step(1'b0, 1'b1, 32'(k), 1'b1, 6'd5);
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL fill_d5 adv%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
         if (k == 6) begin
            n_tests++;
            if (out_d !== 32'd1 || out_valid !== 1'b1 || filling !== 1'b0) begin
               n_fail++;
               $display("FAIL fill_d5_first: got %h/%b/%b want 1/1/0", out_d, out_valid, filling);
            end
         end
      end
   endtask

   task automatic test_d1();
      for (int k = 0; k < 12; k++) begin
         logic [WIDTH-1:0] d;
         d = (k == 3) ? 32'hDEADBEEF : $urandom;
         step(1'b0, 1'b1, d, 1'($urandom_range(0, 1)), 6'd1);
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL d1 adv%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
         if (k == 4) begin
            n_tests++;
            if (out_d !== 32'hDEADBEEF) begin
               n_fail++;
               $display("FAIL d1_deadbeef: got %h want deadbeef", out_d);
            end
         end
      end
   endtask

   task automatic test_depth_wrap();
      for (int k = 0; k < 100; k++) begin
         step(1'b0, 1'b1, 32'h1000 + 32'(k), 1'($urandom_range(0, 3) != 0), 6'(DEPTH));
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL depth_wrap adv%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
      end
   endtask

   task automatic test_stall();
      logic [WIDTH-1:0] held;
      logic             held_v;
      for (int k = 0; k < 40; k++) begin
         logic e;
         e = !(k >= 20 && k < 24);
         if (k == 20) begin held = out_d; held_v = out_valid; end
         step(1'b0, e, $urandom, 1'b1, e ? 6'd8 : 6'($urandom_range(0, 63)));
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL stall cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
         if (!e) begin
            n_tests++;
            if (out_d !== held || out_valid !== held_v) begin
               n_fail++;
               $display("FAIL stall_hold cyc%0d: got %h/%b want %h/%b", k, out_d, out_valid, held, held_v);
            end
         end
      end
   endtask

   task automatic test_delay_change();
      for (int k = 0; k < 30; k++) begin
         step(1'b0, 1'b1, 32'hA000 + 32'(k), 1'b1, (k < 15) ? 6'd8 : 6'd3);
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL delay_change adv%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
         if (k == 18) begin
            n_tests++;
            if (out_d !== 32'hA00F || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL change_first: got %h/%b want 0000a00f/1", out_d, out_valid);
            end
         end
      end
   endtask

   task automatic test_cfg_err();
      for (int k = 0; k < 30; k++) begin
         logic [SELW-1:0] s;
         s = (k == 10) ? 6'd0 : (k == 17) ? 6'd40 : 6'd3;
         step(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), s);
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL cfg_err adv%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
      end
   endtask

   task automatic test_random();
      logic [SELW-1:0] s;
      s = 6'd6;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 24) == 0) s = 6'($urandom_range(0, 40));
         step(1'b0, 1'($urandom_range(0, 4) != 0), $urandom, 1'($urandom_range(0, 1)), s);
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
      end
   endtask

   task automatic test_reset_midstream();
      for (int k = 0; k < 24; k++) begin
         logic r;
         logic [SELW-1:0] s;
         r = (k == 14);
         s = (k == 3) ? 6'd0 : (k < 14) ? 6'd8 : 6'd1;
         step(r, 1'b1, 32'hC000 + 32'(k), 1'b1, s);
         n_tests++;
         if ({out_d, out_valid, filling, cfg_err} !== {exp_out, exp_ov, exp_fill, cfg_mod}) begin
            n_fail++;
            $display("FAIL reset_mid cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                     out_d, out_valid, filling, cfg_err, exp_out, exp_ov, exp_fill, cfg_mod);
         end
         if (k == 16) begin
            n_tests++;
            if (out_d !== 32'hC00F || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL reset_mid_d1: got %h/%b want 0000c00f/1", out_d, out_valid);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      GlobalReset = 1'b1; en = 1'b0; in_d = '0; in_valid = 1'b0; delay_sel = 6'd1;
      step(1'b1, 1'b0, '0, 1'b0, 6'd1);
      test_reset();
      test_fill_d5();
      test_d1();
      test_depth_wrap();
      test_stall();
      test_delay_change();
      test_cfg_err();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
